// File: rtl/cvxif_pkg.sv
// Shared types and constants for the CVXIF result writeback path.
package cvxif_pkg;

  // Instruction id width carried in a queued tag.
  localparam int CVXIF_ID_W = 4;

  // Major opcode of the custom-3 space used by the posit coprocessor.
  localparam logic [6:0] OPC_CUSTOM3 = 7'b1111011;

  // Destination register field inside a 32-bit instruction word.
  localparam int RD_LSB = 7;
  localparam int RD_MSB = 11;

  // One queued tag per accepted instruction, retired in issue order.
  typedef struct packed {
    logic [CVXIF_ID_W-1:0] id;
    logic [4:0]            rd;
    logic                  we;
  } tag_t;

endpackage

// File: rtl/cvxif_tag_fifo.sv
// Show-ahead tag FIFO: same-cycle push+pop, drops pushes while full.
module cvxif_tag_fifo
  import cvxif_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  tag_t             push_tag,
  input  logic             pop,
  output tag_t             pop_tag,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  tag_t             mem_q [DEPTH];
  tag_t             mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_tag  = mem_q[rd_ptr_q];
  // A push into a full queue only lands when a pop frees a slot this cycle.
  assign overflow = push && full && !pop;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = push && (!full || pop);
    do_pop   = pop && !empty;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_tag;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset empties the queue.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Tag storage.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; entries are only read once the count says they are valid.
    mem_q <= mem_d;
  end

endmodule

// File: rtl/cvxif_result_stage.sv
// Writeback stage: pairs coprocessor results with in-order issue tags.
module cvxif_result_stage
  import cvxif_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ID_W   = CVXIF_ID_W,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_valid,
  input  logic                     issue_ready,
  input  logic                     issue_resp_accept,
  input  logic                     issue_resp_writeback,
  input  logic [31:0]              issue_req_instr,
  input  logic [ID_W-1:0]          issue_req_id,
  output logic                     issue_hold,
  input  logic                     cop_result_valid,
  output logic                     cop_result_ready,
  input  logic [DATA_W-1:0]        cop_result_data,
  output logic                     result_valid,
  input  logic                     result_ready,
  output logic [ID_W-1:0]          result_id,
  output logic [4:0]               result_rd,
  output logic                     result_we,
  output logic [DATA_W-1:0]        result_data,
  output logic [$clog2(DEPTH):0]   pending_count,
  output logic                     err_overflow,
  output logic                     err_orphan
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  tag_t              push_tag;
  tag_t              head_tag;
  logic              push;
  logic              xfer;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_overflow;
  logic [CNT_W-1:0]  fifo_count;

  logic              result_valid_q, result_valid_d;
  logic [ID_W-1:0]   result_id_q,    result_id_d;
  logic [4:0]        result_rd_q,    result_rd_d;
  logic              result_we_q,    result_we_d;
  logic [DATA_W-1:0] result_data_q,  result_data_d;
  logic              err_overflow_q, err_overflow_d;
  logic              err_orphan_q,   err_orphan_d;

  // Opcode and remaining instruction bits are decoded by the coprocessor, not here.
  logic unused_instr;
  assign unused_instr = (^issue_req_instr[31:RD_MSB+1]) ^ (issue_req_instr[RD_LSB-1:0] == OPC_CUSTOM3);

  assign push         = issue_valid && issue_ready && issue_resp_accept;
  assign push_tag.id  = issue_req_id;
  assign push_tag.rd  = issue_req_instr[RD_MSB:RD_LSB];
  // x0 is never written, so a writeback to rd=0 is squashed here.
  assign push_tag.we  = issue_resp_writeback && (issue_req_instr[RD_MSB:RD_LSB] != 5'd0);

  assign cop_result_ready = !rst && !fifo_empty && (!result_valid_q || result_ready);
  assign xfer             = cop_result_valid && cop_result_ready;

  cvxif_tag_fifo #(
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_tag (push_tag),
    .pop      (xfer),
    .pop_tag  (head_tag),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count),
    .overflow (fifo_overflow)
  );

  assign issue_hold    = fifo_full;
  assign pending_count = fifo_count;
  assign result_valid  = result_valid_q;
  assign result_id     = result_id_q;
  assign result_rd     = result_rd_q;
  assign result_we     = result_we_q;
  assign result_data   = result_data_q;
  assign err_overflow  = err_overflow_q;
  assign err_orphan    = err_orphan_q;

  // Output register load/drain and sticky error accumulation.
  always_comb begin
    result_valid_d = result_valid_q;
    result_id_d    = result_id_q;
    result_rd_d    = result_rd_q;
    result_we_d    = result_we_q;
    result_data_d  = result_data_q;
    err_overflow_d = err_overflow_q || fifo_overflow;
    err_orphan_d   = err_orphan_q || (cop_result_valid && fifo_empty);
    if (xfer) begin
      result_valid_d = 1'b1;
      result_id_d    = head_tag.id;
      result_rd_d    = head_tag.rd;
      result_we_d    = head_tag.we;
      result_data_d  = cop_result_data;
    end else if (result_ready) begin
      result_valid_d = 1'b0;
    end
  end

  // Result and error registers; reset clears everything including held data.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_valid_q <= 1'b0;
      result_id_q    <= '0;
      result_rd_q    <= '0;
      result_we_q    <= 1'b0;
      result_data_q  <= '0;
      err_overflow_q <= 1'b0;
      err_orphan_q   <= 1'b0;
    end else begin
      result_valid_q <= result_valid_d;
      result_id_q    <= result_id_d;
      result_rd_q    <= result_rd_d;
      result_we_q    <= result_we_d;
      result_data_q  <= result_data_d;
      err_overflow_q <= err_overflow_d;
      err_orphan_q   <= err_orphan_d;
    end
  end

endmodule
